// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped I/O page (LEDs, switches, sticky button flag, cycle counter)
// for the 16-bit core's MEM stage. Load data is combinational from the address.
module data_mem_io #(
    parameter int RAM_AW = 7,
    parameter int SW_W   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     dmemaddr,
    input  logic [15:0]     dmemwdata,
    input  logic            dmemwrite,
    input  logic            dmemread,
    output logic [15:0]     dmemrdata,
    input  logic [SW_W-1:0] switches,
    input  logic            button,
    output logic [SW_W-1:0] leds
);

    localparam logic [14:0] LED_WORD = 15'h7F80;
    localparam logic [14:0] SW_WORD  = 15'h7F81;
    localparam logic [14:0] BTN_WORD = 15'h7F82;
    localparam logic [14:0] CNT_WORD = 15'h7F83;

    logic [15:0]       ram_q [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx;
    logic [14:0]       word_addr;
    logic              is_ram, is_led, is_sw, is_btn, is_cnt;

    logic [SW_W-1:0] leds_q, leds_d;
    logic [SW_W-1:0] sw_sync1_q, sw_sync1_d;
    logic [SW_W-1:0] sw_sync2_q, sw_sync2_d;
    logic            btn_sync1_q, btn_sync1_d;
    logic            btn_sync2_q, btn_sync2_d;
    logic            btn_prev_q, btn_prev_d;
    logic            flag_q, flag_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            btn_rise, btn_clear;

    logic unused_addr_bit;
    assign unused_addr_bit = dmemaddr[0];

    always_comb begin
        word_addr = dmemaddr[15:1];
        ram_idx   = dmemaddr[RAM_AW:1];
        is_ram    = (dmemaddr[15:RAM_AW+1] == '0);
        is_led    = (word_addr == LED_WORD);
        is_sw     = (word_addr == SW_WORD);
        is_btn    = (word_addr == BTN_WORD);
        is_cnt    = (word_addr == CNT_WORD);
    end

    // Next-state logic; a rising edge on the flag beats a same-cycle clear.
    always_comb begin
        leds_d = leds_q;
        if (dmemwrite && is_led) begin
            leds_d = dmemwdata[SW_W-1:0];
        end
        sw_sync1_d  = switches;
        sw_sync2_d  = sw_sync1_q;
        btn_sync1_d = button;
        btn_sync2_d = btn_sync1_q;
        btn_prev_d  = btn_sync2_q;
        btn_rise    = btn_sync2_q & ~btn_prev_q;
        btn_clear   = is_btn & (dmemread | dmemwrite);
        flag_d      = btn_rise | (flag_q & ~btn_clear);
        cnt_d       = (dmemwrite && is_cnt) ? 16'h0000 : cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leds_q      <= '0;
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            btn_sync1_q <= 1'b0;
            btn_sync2_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            flag_q      <= 1'b0;
            cnt_q       <= 16'h0000;
        end else begin
            leds_q      <= leds_d;
            sw_sync1_q  <= sw_sync1_d;
            sw_sync2_q  <= sw_sync2_d;
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
            btn_prev_q  <= btn_prev_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
        end
    end

    // RAM has no reset; stores presented during reset are dropped.
    always_ff @(posedge clock) begin
        if (!reset && dmemwrite && is_ram) begin
            ram_q[ram_idx] <= dmemwdata;
        end
    end

    always_comb begin
        dmemrdata = 16'h0000;
        if (is_ram) begin
            dmemrdata = ram_q[ram_idx];
        end else if (is_led) begin
            dmemrdata = {{(16-SW_W){1'b0}}, leds_q};
        end else if (is_sw) begin
            dmemrdata = {{(16-SW_W){1'b0}}, sw_sync2_q};
        end else if (is_btn) begin
            dmemrdata = {15'h0000, flag_q};
        end else if (is_cnt) begin
            dmemrdata = cnt_q;
        end
    end

    assign leds = leds_q;

endmodule
